// File: rtl/dpram_burst_initiator.sv
// dpram_burst_initiator: turns burst commands into single-beat accesses on one RAM port.
// Define DPRAM_INIT_WRAP_ERR_EN to reject bursts that would run past the top address.
module dpram_burst_initiator #(
  parameter int ADDR_WIDTH   = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int LEN_WIDTH    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t                  r_state;
  logic                    r_cmd_ready, r_wr_ready, r_busy, r_done;
  logic [ADDR_WIDTH-1:0]   r_cur;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH:0]      r_cnt;
  logic                    r_ram_en, r_ram_we;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic [DATA_WIDTH-1:0]   r_ram_din;
  logic [READ_LATENCY-1:0] r_infl;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wp, r_rp;
  logic [CW-1:0]           r_count;
  logic                    w_req, w_push, w_pop, w_last, w_credit;
  logic [7:0]              w_out;
`ifdef DPRAM_INIT_WRAP_ERR_EN
  localparam int SW = ADDR_WIDTH + LEN_WIDTH + 1;
  logic r_err;
  logic w_wrap;
  assign w_wrap = (SW'(i_cmd_addr) + SW'(i_cmd_len)) > SW'(2**ADDR_WIDTH - 1);
  assign o_err  = r_err;
`else
  assign o_err  = 1'b0;
`endif
  assign w_req      = r_ram_en & ~r_ram_we;
  assign w_push     = r_infl[READ_LATENCY-1];
  assign o_rd_valid = (r_count != '0);
  assign w_pop      = o_rd_valid & i_rd_ready;
  assign w_last     = (r_cnt == {1'b0, r_len});
  // every read not yet handed to the client holds a FIFO slot; a pop this cycle frees one
  assign w_out      = 8'(w_req) + 8'($countones(r_infl)) + 8'(r_count) - 8'(w_pop);
  assign w_credit   = (w_out < 8'(FIFO_DEPTH));
  assign o_rd_data  = o_rd_valid ? r_mem[r_rp] : '0;
  assign o_cmd_ready = r_cmd_ready;
  assign o_wr_ready  = r_wr_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ram_en    = r_ram_en;
  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_din   = r_ram_din;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cur       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
`ifdef DPRAM_INIT_WRAP_ERR_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_done   <= 1'b0;
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
`ifdef DPRAM_INIT_WRAP_ERR_EN
      r_err    <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (r_cmd_ready && i_cmd_valid) begin
`ifdef DPRAM_INIT_WRAP_ERR_EN
            if (w_wrap) r_err <= 1'b1; else
`endif
            begin
              r_state     <= i_cmd_write ? WRITE : READ;
              r_cmd_ready <= 1'b0;
              r_wr_ready  <= i_cmd_write;
              r_busy      <= 1'b1;
              r_cur       <= i_cmd_addr;
              r_len       <= i_cmd_len;
              r_cnt       <= '0;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (i_wr_valid) begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_cur;
            r_ram_din  <= i_wr_data;
            r_cur      <= r_cur + 1'b1;
            r_cnt      <= r_cnt + 1'b1;
            if (w_last) begin
              r_state     <= IDLE;
              r_wr_ready  <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_credit) begin
            r_ram_en   <= 1'b1;
            r_ram_addr <= r_cur;
            r_cur      <= r_cur + 1'b1;
            r_cnt      <= r_cnt + 1'b1;
            if (w_last) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_out == 8'd0) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_infl  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_infl  <= (r_infl << 1) | READ_LATENCY'(w_req);
      if (w_push) r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_ram_dout;
  end
endmodule

// File: tb/tb_dpram_burst_initiator.sv
// tb_dpram_burst_initiator: table, hand-written and random bursts against a RAM model and shadow memory.
module tb_dpram_burst_initiator;
  localparam int AW = 3, DW = 8, RL = 3, LW = 4, DEPTH = RL + 2;
`ifdef DPRAM_INIT_WRAP_ERR_EN
  localparam bit WRAP_ERR = 1'b1;
`else
  localparam bit WRAP_ERR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] ram_dout, rd_data, ram_din;
  logic [AW-1:0] ram_addr;
  logic cmd_ready, wr_ready, rd_valid, ram_en, ram_we, busy, done, err;
  logic [26:0] outs;

  dpram_burst_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .i_rd_ready(rd_ready),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_din(ram_din),
    .i_ram_dout(ram_dout), .o_busy(busy), .o_done(done), .o_err(err)
  );

  assign outs = {cmd_ready, wr_ready, rd_valid, ram_en, ram_we, busy, done, err, rd_data, ram_addr, ram_din};
  always #5 clk = ~clk;

  // RAM port with RL-cycle read latency; junk on the output when no read was issued
  logic [DW-1:0] ram [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  logic [DW-1:0] pipe [RL];
  assign ram_dout = pipe[RL-1];
  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr] : 8'hEE;
    if (ram_en && ram_we) ram[ram_addr] <= ram_din;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  int wcyc[$], rcyc[$], icyc[$], dq[$], eq[$];
  int iss = 0, pops = 0, max_occ = 0, bad = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      iss = 0;
      pops = 0;
    end else begin
      if (ram_en && ram_we) begin wq.push_back({ram_addr, ram_din}); wcyc.push_back(cyc); end
      if (ram_en && !ram_we) begin iss++; icyc.push_back(cyc); end
      if (iss - pops > max_occ) max_occ = iss - pops;
      if (rd_valid && rd_ready) begin rq.push_back(rd_data); rcyc.push_back(cyc); pops++; end
      if (done) dq.push_back(cyc);
      if (err) eq.push_back(cyc);
      if ((done && !cmd_ready) || (busy && cmd_ready) || (wr_ready && !busy)) bad++;
    end
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] shadow [8];
  int acc = 0;
  bit timeout = 0, busy_seen = 0;

  task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input logic [DW-1:0] base, input int mode);
    int k = 0, t = 0;
    wq.delete(); wcyc.delete(); rq.delete(); rcyc.delete(); icyc.delete(); dq.delete(); eq.delete();
    max_occ = 0;
    busy_seen = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    wr_valid = wr; wr_data = base; rd_ready = (mode != 1);
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    acc = cyc + 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    while (dq.size() == 0 && eq.size() == 0 && t < 200) begin
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? t[0] : 1'($urandom_range(0, 1));
      if (mode == 2 && wr) wr_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (t == 0) busy_seen = busy;
      if (wr_ready && wr_valid) k++;
      @(posedge clk); #1;
      wr_data = base + 8'(k);
      t++;
    end
    timeout = (t >= 200);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_burst(input string tag, input logic wr, input logic [AW-1:0] a,
                             input logic [LW-1:0] l, input logic [DW-1:0] base,
                             input int exp_acc, input int exp_done, input int exp_err, input bit timing);
    logic [AW-1:0] ea;
    chk({tag, " timeout"}, timeout, 0);
    chk({tag, " done count"}, dq.size(), exp_done);
    chk({tag, " err count"}, eq.size(), exp_err);
    chk({tag, " busy"}, busy_seen, exp_done);
    chk({tag, " occupancy"}, max_occ <= DEPTH, 1);
    chk({tag, " write beats"}, wq.size(), wr ? exp_acc : 0);
    chk({tag, " read issues"}, icyc.size(), wr ? 0 : exp_acc);
    if (eq.size() > 0) chk({tag, " err cycle"}, eq[0], acc);
    if (wr) begin
      for (int i = 0; i < exp_acc && i < wq.size(); i++) begin
        ea = a + AW'(i);
        chk($sformatf("%s write%0d", tag, i), wq[i], {ea, base + DW'(i)});
        shadow[ea] = base + DW'(i);
      end
    end else begin
      chk({tag, " read beats"}, rq.size(), exp_acc);
      for (int i = 0; i < exp_acc && i < rq.size(); i++) begin
        ea = a + AW'(i);
        chk($sformatf("%s beat%0d", tag, i), rq[i], shadow[ea]);
      end
    end
    if (timing && exp_done == 1 && dq.size() > 0) begin
      if (wr && wcyc.size() > 0) begin
        chk({tag, " first write cycle"}, wcyc[0], acc + 1);
        chk({tag, " write span"}, wcyc[wcyc.size()-1] - wcyc[0], l);
        chk({tag, " done cycle"}, dq[0], acc + 1 + l);
      end else if (!wr && rcyc.size() > 0) begin
        chk({tag, " first beat cycle"}, rcyc[0], acc + RL + 2);
        chk({tag, " beat span"}, rcyc[rcyc.size()-1] - rcyc[0], l);
        chk({tag, " done cycle"}, dq[0], acc + RL + 3 + l);
      end
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [DW-1:0] base;
    int            mode;
    int            exp_acc;
    int            exp_done;
    int            exp_err;
  } vec_t;
  vec_t tbl [9];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) shadow[i] = 8'h10 + 8'(i);
    tbl[0] = '{1'b1, 3'd2, 4'd3, 8'hA1, 0, 4, 1, 0};
    tbl[1] = '{1'b0, 3'd2, 4'd3, 8'h00, 0, 4, 1, 0};
    tbl[2] = '{1'b0, 3'd2, 4'd3, 8'h00, 1, 4, 1, 0};
    tbl[3] = '{1'b1, 3'd6, 4'd3, 8'hB1, 0, WRAP_ERR ? 0 : 4, WRAP_ERR ? 0 : 1, WRAP_ERR ? 1 : 0};
    tbl[4] = '{1'b0, 3'd6, 4'd3, 8'h00, 1, WRAP_ERR ? 0 : 4, WRAP_ERR ? 0 : 1, WRAP_ERR ? 1 : 0};
    tbl[5] = '{1'b1, 3'd0, 4'd7, 8'hC0, 0, 8, 1, 0};
    tbl[6] = '{1'b0, 3'd7, 4'd0, 8'h00, 0, 1, 1, 0};
    tbl[7] = '{1'b0, 3'd0, 4'd7, 8'h00, 1, 8, 1, 0};
    tbl[8] = '{1'b1, 3'd3, 4'd0, 8'h5A, 0, 1, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 32'(outs), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready before first edge", cmd_ready, 0);
    @(negedge clk);
    chk("ready after release", cmd_ready, 1);

    for (int r = 0; r < 9; r++) begin
      run_cmd(tbl[r].wr, tbl[r].addr, tbl[r].len, tbl[r].base, tbl[r].mode);
      check_burst($sformatf("row%0d", r), tbl[r].wr, tbl[r].addr, tbl[r].len, tbl[r].base,
                  tbl[r].exp_acc, tbl[r].exp_done, tbl[r].exp_err, tbl[r].mode == 0);
    end

    rq.delete(); icyc.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_len = 4'd7; rd_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy before reset", busy, 1);
    chk("reads in flight", icyc.size() >= 2, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", 32'(outs), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_ready = 1'b1;
    rq.delete();
    repeat (8) @(negedge clk);
    chk("no stale beats", rq.size(), 0);
    chk("ready after mid reset", cmd_ready, 1);
    run_cmd(1'b0, 3'd2, 4'd3, 8'h00, 0);
    check_burst("post-reset", 1'b0, 3'd2, 4'd3, 8'h00, 4, 1, 0, 1'b1);

    for (int r = 0; r < 24; r++) begin
      logic          wr;
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      logic [DW-1:0] base;
      int            e;
      wr   = 1'($urandom_range(0, 1));
      a    = AW'($urandom_range(0, 7));
      l    = LW'($urandom_range(0, 15));
      base = DW'($urandom);
      e    = (WRAP_ERR && (int'(a) + int'(l) > 7)) ? 1 : 0;
      run_cmd(wr, a, l, base, 2);
      check_burst($sformatf("rand%0d", r), wr, a, l, base, e ? 0 : int'(l) + 1, e ? 0 : 1, e, 1'b0);
    end

    chk("handshake invariants", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpram_burst_initiator.md
# dpram_burst_initiator

Single-clock initiator that drives one port of the team's dual-port RAM on behalf of a client. Accepts burst read/write commands over a valid/ready handshake and converts each into a sequence of single-beat RAM accesses with auto-incrementing addresses. Matches the RAM's fixed read latency with an in-flight tracker and a credit-limited response FIFO, so read data never drops under client backpressure. Sits between a DMA/CPU-side client and RAM port A or B.

## Interface
- ADDR_WIDTH, 3, RAM address width; address space 2**ADDR_WIDTH words
- DATA_WIDTH, 8, RAM data width
- READ_LATENCY, 1, RAM read latency in cycles (≥1); must equal the RAM's setting
- LEN_WIDTH, 4, burst length field width; beats = i_cmd_len + 1 (1..2**LEN_WIDTH)

- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_write  in  1  1 = write burst, 0 = read burst
- i_cmd_addr  in  ADDR_WIDTH  start address
- i_cmd_len  in  LEN_WIDTH  beats − 1
- i_wr_valid  in  1  write beat offered
- i_wr_data  in  DATA_WIDTH  write beat data
- o_wr_ready  out  1  high only in WRITE
- o_rd_valid  out  1  read beat available (FIFO not empty)
- o_rd_data  out  DATA_WIDTH  FIFO head
- i_rd_ready  in  1  client accepts read beat
- o_ram_en  out  1  RAM enable (registered)
- o_ram_we  out  1  RAM write enable (registered)
- o_ram_addr  out  ADDR_WIDTH  RAM address (registered)
- o_ram_din  out  DATA_WIDTH  RAM write data (registered)
- i_ram_dout  in  DATA_WIDTH  RAM read data
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse on burst completion
- o_err  out  1  one-cycle pulse on rejected command (macro-enabled only; tied 0 otherwise)

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: o_cmd_ready=1; on i_cmd_valid, latch addr/len/write, beat counter=0; go WRITE or READ.
- WRITE: each cycle with i_wr_valid=1 (handshake), register o_ram_en=1, o_ram_we=1, o_ram_addr=cur, o_ram_din=i_wr_data; cur+=1; after beat len → IDLE, o_done next cycle.
- READ: issue read (o_ram_en=1, o_ram_we=0) when inflight+fifo_count < FIFO_DEPTH (= READ_LATENCY+2); after last issue → DRAIN.
- DRAIN: wait until inflight=0 and FIFO empty (last beat popped) → IDLE, o_done.
- Cycles without an issued beat: o_ram_en=0, o_ram_we=0; addr/din hold.
- Inflight tracker: READ_LATENCY-deep valid shift register; its tail pushes i_ram_dout into the FIFO.
- Address arithmetic modulo 2**ADDR_WIDTH (wraps top→0); beat counter LEN_WIDTH+1 bits.
- FIFO push and pop in the same cycle is legal; count unchanged.
- Reset (any time, including mid-burst): state IDLE, in-flight and FIFO contents discarded, all outputs 0 (o_cmd_ready goes 1 in the first cycle after release).

## Timing
- Command accepted at edge 0 → first RAM request visible in cycle 1 (write: if i_wr_valid already high in cycle 0 of WRITE).
- Read request in cycle n → i_ram_dout sampled end of cycle n+READ_LATENCY → o_rd_valid in cycle n+READ_LATENCY+1.
- With i_rd_ready held high: one read beat per cycle sustained; with i_wr_valid held high: one write beat per cycle.
- o_done: exactly one cycle, coincident with return to IDLE (o_cmd_ready=1 same cycle); back-to-back commands lose no cycle beyond that.

## Configuration
- DPRAM_INIT_WRAP_ERR_EN defined: a command with i_cmd_addr + i_cmd_len > 2**ADDR_WIDTH − 1 is accepted but not executed; o_err pulses one cycle after acceptance, no RAM access, no o_done, FSM stays IDLE.
- Not defined: such bursts wrap to address 0 and complete normally; o_err constant 0.

## Test plan
- Reset, write burst addr=2 len=3 data 0xA1..0xA4 with i_wr_valid constant → RAM writes to 2,3,4,5 on 4 consecutive cycles, o_done one pulse.
- Read burst addr=2 len=3, i_rd_ready=1, READ_LATENCY=1 → o_rd_valid from cycle 3 after accept, data 0xA1..0xA4 back-to-back.
- Same read with i_rd_ready toggling 1/0 and READ_LATENCY=3 → all 4 beats in order, none dropped/duplicated, inflight+fifo never exceeds 5.
- Write addr=6 len=3 → writes to 6,7,0,1 (macro off); with DPRAM_INIT_WRAP_ERR_EN → o_err pulse, o_ram_en stays 0.
- Assert i_rst_n=0 mid read burst with 2 beats in flight → all outputs 0 immediately; after release o_rd_valid stays 0, next command runs normally.
